ex_mdu: RTL and testbench

EX_MDU -- requirements
Module: ex_mdu

---
 rtl/ex_mdu_if.sv | 35 +++
 rtl/ex_mdu.sv | 163 ++++++++++++++++
 tb/tb_ex_mdu.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_if.sv
// rtl/ex_mdu_if.sv - EX-stage to MDU request/result bundle; div0_o present only with MDU_DIV0_FLAG_EN
interface ex_mdu_if #(
   parameter int DATA_W = 32
);
   logic                  start_i;
   logic [2:0]            op_i;
   logic [DATA_W-1:0]     opa_i;
   logic [DATA_W-1:0]     opb_i;
   logic [2*DATA_W-1:0]   hilo_i;
   logic                  annul_i;
   logic                  busy_o;
   logic                  valid_o;
   logic [2*DATA_W-1:0]   result_o;
`ifdef MDU_DIV0_FLAG_EN
   logic                  div0_o;

   modport master (
      output start_i, op_i, opa_i, opb_i, hilo_i, annul_i,
      input  busy_o, valid_o, result_o, div0_o
   );
   modport slave (
      input  start_i, op_i, opa_i, opb_i, hilo_i, annul_i,
      output busy_o, valid_o, result_o, div0_o
   );
`else
   modport master (
      output start_i, op_i, opa_i, opb_i, hilo_i, annul_i,
      input  busy_o, valid_o, result_o
   );
   modport slave (
      input  start_i, op_i, opa_i, opb_i, hilo_i, annul_i,
      output busy_o, valid_o, result_o
   );
`endif
endinterface

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - iterative multiply/MAC/divide unit; MDU_DIV0_FLAG_EN adds the div0_o result flag
module ex_mdu #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic     clk,
   input  logic     rst_n,
   ex_mdu_if.slave  mdu
);
   localparam int W = DATA_W;

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_ACC, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [W-1:0]       b_q, b_d;
   logic [2*W-1:0]     wk_q, wk_d;
   logic [2*W-1:0]     hilo_q, hilo_d;
   logic [2*W-1:0]     res_q, res_d;
   logic               mac_q, mac_d;
   logic               sub_q, sub_d;
   logic               neg_q, neg_d;
   logic               negr_q, negr_d;
   logic               div0_q, div0_d;

   logic               sgn, a_neg, b_neg, is_div_req;
   logic [W-1:0]       a_mag, b_mag;
   logic [W:0]         mul_sum;
   logic [2*W-1:0]     mul_next, prod_s;
   logic [W:0]         div_shift, div_diff;
   logic [W-1:0]       div_rem, quo_s, rem_s;
   logic [2*W-1:0]     div_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         b_q     <= '0;
         wk_q    <= '0;
         hilo_q  <= '0;
         res_q   <= '0;
         mac_q   <= 1'b0;
         sub_q   <= 1'b0;
         neg_q   <= 1'b0;
         negr_q  <= 1'b0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         b_q     <= b_d;
         wk_q    <= wk_d;
         hilo_q  <= hilo_d;
         res_q   <= res_d;
         mac_q   <= mac_d;
         sub_q   <= sub_d;
         neg_q   <= neg_d;
         negr_q  <= negr_d;
         div0_q  <= div0_d;
      end
   end

   // wk_q holds {partial product} while multiplying and {remainder, dividend/quotient} while dividing
   always_comb begin
      sgn        = ~mdu.op_i[0];
      a_neg      = sgn & mdu.opa_i[W-1];
      b_neg      = sgn & mdu.opb_i[W-1];
      a_mag      = a_neg ? -mdu.opa_i : mdu.opa_i;
      b_mag      = b_neg ? -mdu.opb_i : mdu.opb_i;
      is_div_req = (mdu.op_i[2:1] == 2'b11);

      mul_sum    = {1'b0, wk_q[2*W-1:W]} + (wk_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
      mul_next   = {mul_sum, wk_q[W-1:1]};
      prod_s     = neg_q ? -mul_next : mul_next;

      div_shift  = {wk_q[2*W-1:W], wk_q[W-1]};
      div_diff   = div_shift - {1'b0, b_q};
      div_rem    = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
      div_next   = {div_rem, wk_q[W-2:0], ~div_diff[W]};
      quo_s      = neg_q  ? -div_next[W-1:0]     : div_next[W-1:0];
      rem_s      = negr_q ? -div_next[2*W-1:W]   : div_next[2*W-1:W];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      b_d     = b_q;
      wk_d    = wk_q;
      hilo_d  = hilo_q;
      res_d   = res_q;
      mac_d   = mac_q;
      sub_d   = sub_q;
      neg_d   = neg_q;
      negr_d  = negr_q;
      div0_d  = div0_q;

      if (mdu.annul_i && state_q != S_IDLE) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mdu.start_i && !mdu.annul_i) begin
                  b_d    = b_mag;
                  wk_d   = {{W{1'b0}}, a_mag};
                  hilo_d = mdu.hilo_i;
                  cnt_d  = CNT_W'(W - 1);
                  mac_d  = (mdu.op_i[2:1] == 2'b01) || (mdu.op_i[2:1] == 2'b10);
                  sub_d  = mdu.op_i[2];
                  neg_d  = a_neg ^ b_neg;
                  negr_d = a_neg;
                  div0_d = 1'b0;
                  if (is_div_req && mdu.opb_i == '0) begin
                     res_d   = {mdu.opa_i, {W{1'b1}}};
                     div0_d  = 1'b1;
                     state_d = S_DONE;
                  end else if (is_div_req) begin
                     state_d = S_DIV;
                  end else begin
                     state_d = S_MUL;
                  end
               end
            end
            S_MUL: begin
               wk_d = mul_next;
               if (cnt_q == '0) begin
                  if (mac_q) begin
                     wk_d    = prod_s;
                     state_d = S_ACC;
                  end else begin
                     res_d   = prod_s;
                     state_d = S_DONE;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            S_DIV: begin
               wk_d = div_next;
               if (cnt_q == '0) begin
                  res_d   = {rem_s, quo_s};
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            S_ACC: begin
               res_d   = sub_q ? (hilo_q - wk_q) : (hilo_q + wk_q);
               state_d = S_DONE;
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign mdu.busy_o   = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_ACC);
   assign mdu.valid_o  = (state_q == S_DONE);
   assign mdu.result_o = res_q;
`ifdef MDU_DIV0_FLAG_EN
   assign mdu.div0_o   = (state_q == S_DONE) && div0_q;
`endif
endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - directed and random checks of ex_mdu against an arithmetic reference model
module tb_ex_mdu;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ex_mdu_if #(.DATA_W(W)) mdu_if ();

   ex_mdu #(.DATA_W(W), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mdu   (mdu_if)
   );

   int checks = 0;
   int passed = 0;
   logic [63:0] last_res;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hilo);
      longint sa, sb, q, r, p;
      sa = op[0] ? longint'(a) : longint'(signed'(a));
      sb = op[0] ? longint'(b) : longint'(signed'(b));
      if (op[2:1] == 2'b11) begin
         if (b == 32'h0) return {a, 32'hFFFF_FFFF};
         q = sa / sb;
         r = sa % sb;
         return {r[31:0], q[31:0]};
      end
      p = sa * sb;
      if (op[2:1] == 2'b01) return hilo + 64'(p);
      if (op[2:1] == 2'b10) return hilo - 64'(p);
      return 64'(p);
   endfunction

   function automatic int model_lat(input logic [2:0] op, input logic [31:0] b);
      if (op[2:1] == 2'b11 && b == 32'h0) return 1;
      if (op[2:1] == 2'b01 || op[2:1] == 2'b10) return W + 2;
      return W + 1;
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] hilo);
      int lat;
      int busy_cnt;
      int exp_lat;
      logic [63:0] exp_r;
      exp_r   = model(op, a, b, hilo);
      exp_lat = model_lat(op, b);
      @(negedge clk);
      mdu_if.start_i = 1'b1;
      mdu_if.op_i    = op;
      mdu_if.opa_i   = a;
      mdu_if.opb_i   = b;
      mdu_if.hilo_i  = hilo;
      @(negedge clk);
      mdu_if.start_i = 1'b0;
      lat      = 1;
      busy_cnt = 0;
      while (!mdu_if.valid_o && lat < 100) begin
         if (mdu_if.busy_o) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      check($sformatf("latency op%0d a=%h b=%h", op, a, b), 64'(lat), 64'(exp_lat));
      check($sformatf("result op%0d a=%h b=%h", op, a, b), mdu_if.result_o, exp_r);
      check($sformatf("busy_cycles op%0d", op), 64'(busy_cnt), 64'(exp_lat - 1));
`ifdef MDU_DIV0_FLAG_EN
      check("div0_at_valid", 64'(mdu_if.div0_o), 64'(op[2:1] == 2'b11 && b == 32'h0));
`endif
      last_res = exp_r;
      @(negedge clk);
      check("valid_one_cycle", 64'(mdu_if.valid_o), 64'(0));
      check("result_held", mdu_if.result_o, exp_r);
`ifdef MDU_DIV0_FLAG_EN
      check("div0_after_done", 64'(mdu_if.div0_o), 64'(0));
`endif
   endtask

   initial begin
      int vcount;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      mdu_if.start_i = 1'b0;
      mdu_if.op_i    = 3'b000;
      mdu_if.opa_i   = '0;
      mdu_if.opb_i   = '0;
      mdu_if.hilo_i  = '0;
      mdu_if.annul_i = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_busy", 64'(mdu_if.busy_o), 64'(0));
      check("reset_valid", 64'(mdu_if.valid_o), 64'(0));
      check("reset_result", mdu_if.result_o, 64'h0);
      rst_n = 1'b1;

      run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 64'h0);
      check("mult_const", last_res, 64'hFFFF_FFFF_FFFF_FFFA);
      run_op(3'b100, 32'd5, 32'd4, 64'h0000_0000_0000_0064);
      check("msub_const", last_res, 64'h0000_0000_0000_0050);
      run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 64'h0);
      check("div_const", last_res, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(3'b111, 32'h1234_5678, 32'd0, 64'h0);
      check("div0_const", last_res, 64'h1234_5678_FFFF_FFFF);
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0);
      check("div_overflow_const", last_res, 64'h0000_0000_8000_0000);
      run_op(3'b010, 32'h8000_0000, 32'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op(3'b110, 32'h0000_0009, 32'hFFFF_FFFC, 64'h0);

      // annul together with start mid-divide
      @(negedge clk);
      mdu_if.start_i = 1'b1;
      mdu_if.op_i    = 3'b111;
      mdu_if.opa_i   = 32'd100;
      mdu_if.opb_i   = 32'd7;
      @(negedge clk);
      mdu_if.start_i = 1'b0;
      repeat (9) @(negedge clk);
      mdu_if.annul_i = 1'b1;
      mdu_if.start_i = 1'b1;
      mdu_if.op_i    = 3'b000;
      @(negedge clk);
      mdu_if.annul_i = 1'b0;
      mdu_if.start_i = 1'b0;
      check("annul_busy", 64'(mdu_if.busy_o), 64'(0));
      check("annul_valid", 64'(mdu_if.valid_o), 64'(0));
      check("annul_result", mdu_if.result_o, last_res);
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mdu_if.valid_o || mdu_if.busy_o) vcount++;
      end
      check("annul_no_activity", 64'(vcount), 64'(0));
      run_op(3'b001, 32'd7, 32'd6, 64'h0);
      check("multu_after_annul", last_res, 64'h2A);

      // reset pulse in the middle of a MADD
      @(negedge clk);
      mdu_if.start_i = 1'b1;
      mdu_if.op_i    = 3'b010;
      mdu_if.opa_i   = 32'd11;
      mdu_if.opb_i   = 32'd13;
      mdu_if.hilo_i  = 64'h55;
      @(negedge clk);
      mdu_if.start_i = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_mid_busy", 64'(mdu_if.busy_o), 64'(0));
      check("rst_mid_valid", 64'(mdu_if.valid_o), 64'(0));
      check("rst_mid_result", mdu_if.result_o, 64'h0);
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mdu_if.valid_o) vcount++;
      end
      check("rst_no_valid", 64'(vcount), 64'(0));

      for (int n = 0; n < 40; n++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'h0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         run_op(rop, ra, rb, {$urandom, $urandom});
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
